// File: rtl/nbody_pkg.sv
// Shared types and constants for the n-body force path.
package nbody_pkg;

   localparam int FORCE_W   = 16;
   localparam int N_DEFAULT = 256;

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      DRAIN,
      STREAM,
      CLR
   } seq_state_t;

endpackage

// File: rtl/force_frame_sequencer_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
module rr_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic                       CLK_IN,
   input  logic                       RESET_IN,
   input  logic                       clear,
   input  logic [NUM_REQ-1:0]         req,
   input  logic                       advance,
   input  logic [$clog2(NUM_REQ)-1:0] grant_idx_in,
   output logic [NUM_REQ-1:0]         grant
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int SUM_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NUM_REQ - 1);

   logic [PTR_W-1:0] ptr_reg;
   logic [PTR_W-1:0] ptr_next;
   logic [SUM_W-1:0] sum;
   logic [PTR_W-1:0] cand;
   logic             found;

   // The requester after the one just served gets first look next time
   assign ptr_next = (grant_idx_in == LAST_REQ) ? '0 : grant_idx_in + 1'b1;

   // Pointer register: reset to requester 0 at reset and at each new frame
   always_ff @(posedge CLK_IN or negedge RESET_IN) begin
      if (!RESET_IN) begin
         ptr_reg <= '0;
      end else if (clear) begin
         ptr_reg <= '0;
      end else if (advance) begin
         ptr_reg <= ptr_next;
      end
   end

   // Scan requesters starting at the pointer, wrapping modulo NUM_REQ
   always_comb begin
      grant = '0;
      found = 1'b0;
      sum   = '0;
      cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, ptr_reg} + SUM_W'(k);
         if (sum >= SUM_W'(NUM_REQ)) begin
            sum = sum - SUM_W'(NUM_REQ);
         end
         cand = sum[PTR_W-1:0];
         if (!found && req[cand]) begin
            grant[cand] = 1'b1;
            found       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/force_frame_sequencer.sv
// Frame sequencer in front of the force output buffer: arbitrates core writes,
// tracks per-frame index coverage and hands the completed frame to the buffer.
module force_frame_sequencer
   import nbody_pkg::*;
#(
   parameter int N        = N_DEFAULT,
   parameter int IDX_BITS = $clog2(N),
   parameter int NUM_REQ  = 2
) (
   input  logic                        CLK_IN,
   input  logic                        RESET_IN,
   input  logic                        START,
   input  logic                        ABORT,
   input  logic [NUM_REQ-1:0]          REQ_VALID,
   input  logic [NUM_REQ*IDX_BITS-1:0] REQ_IDX,
   input  logic [NUM_REQ*FORCE_W-1:0]  REQ_FX,
   input  logic [NUM_REQ*FORCE_W-1:0]  REQ_FY,
   output logic [NUM_REQ-1:0]          REQ_READY,
   output logic                        BUF_WR_EN,
   output logic [IDX_BITS-1:0]         BUF_WR_IDX,
   output logic [FORCE_W-1:0]          BUF_FORCE_X,
   output logic [FORCE_W-1:0]          BUF_FORCE_Y,
   output logic                        BUF_CLEAR,
   output logic                        BUF_FRAME_VALID,
   input  logic                        BUF_DONE,
   output logic                        BUSY,
   output logic                        FRAME_DONE,
   output logic                        ERR_DUP
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int CNT_W = IDX_BITS + 1;
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(N - 1);

   seq_state_t           state_reg;
   seq_state_t           state_next;
   logic [N-1:0]         bitmap_reg;
   logic [CNT_W-1:0]     count_reg;
   logic                 err_dup_reg;
   logic                 wr_en_reg;
   logic [IDX_BITS-1:0]  wr_idx_reg;
   logic [FORCE_W-1:0]   wr_fx_reg;
   logic [FORCE_W-1:0]   wr_fy_reg;

   logic [NUM_REQ-1:0]   arb_req;
   logic [NUM_REQ-1:0]   grant;
   logic [PTR_W-1:0]     grant_idx;
   logic                 xfer;
   logic                 start_ok;
   logic                 dup_hit;
   logic                 frame_full;
   logic [IDX_BITS-1:0]  sel_idx;
   logic [FORCE_W-1:0]   sel_fx;
   logic [FORCE_W-1:0]   sel_fy;
   logic [IDX_BITS-1:0]  idx_term [NUM_REQ];
   logic [FORCE_W-1:0]   fx_term  [NUM_REQ];
   logic [FORCE_W-1:0]   fy_term  [NUM_REQ];

   assign start_ok = (state_reg == IDLE) && START;

   // Requests are only visible to the arbiter while collecting
   assign arb_req = (state_reg == COLLECT) ? REQ_VALID : '0;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .CLK_IN       (CLK_IN),
      .RESET_IN     (RESET_IN),
      .clear        (start_ok),
      .req          (arb_req),
      .advance      (xfer),
      .grant_idx_in (grant_idx),
      .grant        (grant)
   );

   assign xfer      = |grant;
   assign REQ_READY = grant;

   // Mask each requester's payload by its grant bit so the OR below is a one-hot mux
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sel
      assign idx_term[gi] = grant[gi] ? REQ_IDX[gi*IDX_BITS +: IDX_BITS] : '0;
      assign fx_term[gi]  = grant[gi] ? REQ_FX[gi*FORCE_W +: FORCE_W]    : '0;
      assign fy_term[gi]  = grant[gi] ? REQ_FY[gi*FORCE_W +: FORCE_W]    : '0;
   end

   // Collapse the one-hot grant into an index and the granted payload
   always_comb begin
      grant_idx = '0;
      sel_idx   = '0;
      sel_fx    = '0;
      sel_fy    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            grant_idx = PTR_W'(i);
         end
         sel_idx = sel_idx | idx_term[i];
         sel_fx  = sel_fx  | fx_term[i];
         sel_fy  = sel_fy  | fy_term[i];
      end
   end

   assign dup_hit    = bitmap_reg[sel_idx];
   assign frame_full = xfer && !dup_hit && (count_reg == LAST_COUNT);

   // Next-state and state-decoded buffer/status outputs
   always_comb begin
      state_next      = state_reg;
      BUF_CLEAR       = 1'b0;
      BUF_FRAME_VALID = 1'b0;
      FRAME_DONE      = 1'b0;
      BUSY            = (state_reg != IDLE);
      case (state_reg)
         IDLE: begin
            if (START) begin
               state_next = COLLECT;
            end
         end
         COLLECT: begin
            if (ABORT) begin
               state_next = CLR;
            end else if (frame_full) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            // The final write is on the buffer port this cycle; hold off frame-valid
            state_next = ABORT ? CLR : STREAM;
         end
         STREAM: begin
            BUF_FRAME_VALID = 1'b1;
            if (ABORT || BUF_DONE) begin
               state_next = CLR;
            end
         end
         CLR: begin
            BUF_CLEAR  = 1'b1;
            FRAME_DONE = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge CLK_IN or negedge RESET_IN) begin
      if (!RESET_IN) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Registered write port, coverage bitmap, unique-index count and duplicate flag
   always_ff @(posedge CLK_IN or negedge RESET_IN) begin
      if (!RESET_IN) begin
         wr_en_reg   <= 1'b0;
         wr_idx_reg  <= '0;
         wr_fx_reg   <= '0;
         wr_fy_reg   <= '0;
         bitmap_reg  <= '0;
         count_reg   <= '0;
         err_dup_reg <= 1'b0;
      end else begin
         wr_en_reg <= xfer;
         if (xfer) begin
            wr_idx_reg <= sel_idx;
            wr_fx_reg  <= sel_fx;
            wr_fy_reg  <= sel_fy;
         end
         if (start_ok) begin
            bitmap_reg  <= '0;
            count_reg   <= '0;
            err_dup_reg <= 1'b0;
         end else if (xfer) begin
            // A repeated index still overwrites the buffer but does not count twice
            if (dup_hit) begin
               err_dup_reg <= 1'b1;
            end else begin
               bitmap_reg[sel_idx] <= 1'b1;
               count_reg           <= count_reg + 1'b1;
            end
         end
      end
   end

   assign BUF_WR_EN   = wr_en_reg;
   assign BUF_WR_IDX  = wr_idx_reg;
   assign BUF_FORCE_X = wr_fx_reg;
   assign BUF_FORCE_Y = wr_fy_reg;
   assign ERR_DUP     = err_dup_reg;

endmodule

// File: tb/tb_force_frame_sequencer.sv
// Randomized bench for force_frame_sequencer against a frame-level reference model.
module tb_force_frame_sequencer;

   localparam int N  = 256;
   localparam int IB = 8;
   localparam int NR = 2;

   // Reference-model frame phases
   localparam int P_IDLE    = 0;
   localparam int P_COLLECT = 1;
   localparam int P_LAST    = 2;
   localparam int P_STREAM  = 3;
   localparam int P_CLR     = 4;

   logic            CLK_IN   = 1'b0;
   logic            RESET_IN = 1'b1;
   logic            START    = 1'b0;
   logic            ABORT    = 1'b0;
   logic            BUF_DONE = 1'b0;
   logic [NR-1:0]   REQ_VALID = '0;
   logic [NR*IB-1:0] REQ_IDX  = '0;
   logic [NR*16-1:0] REQ_FX   = '0;
   logic [NR*16-1:0] REQ_FY   = '0;
   logic [NR-1:0]   REQ_READY;
   logic            BUF_WR_EN;
   logic [IB-1:0]   BUF_WR_IDX;
   logic [15:0]     BUF_FORCE_X;
   logic [15:0]     BUF_FORCE_Y;
   logic            BUF_CLEAR;
   logic            BUF_FRAME_VALID;
   logic            BUSY;
   logic            FRAME_DONE;
   logic            ERR_DUP;

   force_frame_sequencer #(.N(N), .IDX_BITS(IB), .NUM_REQ(NR)) dut (
      .CLK_IN          (CLK_IN),
      .RESET_IN        (RESET_IN),
      .START           (START),
      .ABORT           (ABORT),
      .REQ_VALID       (REQ_VALID),
      .REQ_IDX         (REQ_IDX),
      .REQ_FX          (REQ_FX),
      .REQ_FY          (REQ_FY),
      .REQ_READY       (REQ_READY),
      .BUF_WR_EN       (BUF_WR_EN),
      .BUF_WR_IDX      (BUF_WR_IDX),
      .BUF_FORCE_X     (BUF_FORCE_X),
      .BUF_FORCE_Y     (BUF_FORCE_Y),
      .BUF_CLEAR       (BUF_CLEAR),
      .BUF_FRAME_VALID (BUF_FRAME_VALID),
      .BUF_DONE        (BUF_DONE),
      .BUSY            (BUSY),
      .FRAME_DONE      (FRAME_DONE),
      .ERR_DUP         (ERR_DUP)
   );

   always #5 CLK_IN = ~CLK_IN;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model
   int          m_phase = P_IDLE;
   bit          m_written [N];
   int          m_cnt = 0;
   int          m_ptr = 0;
   bit          m_err = 1'b0;
   bit          m_pend = 1'b0;
   logic [IB-1:0] m_pidx = '0;
   logic [15:0] m_pfx = '0;
   logic [15:0] m_pfy = '0;

   // Stimulus: per-requester work lists of {idx, fx, fy}
   logic [39:0] q0 [$];
   logic [39:0] q1 [$];
   int gap_pct     = 0;
   int abort_at    = -1;
   int done_delay  = 3;
   int stream_cyc  = 0;
   bit start_req   = 1'b0;
   bit start_noise = 1'b0;

   // The bench plays the buffer
   logic [31:0] buf_mem [N];
   int dut_wr_cnt = 0;

   function automatic logic [39:0] ent(input int idx, input logic [15:0] fx, input logic [15:0] fy);
      return {IB'(idx), fx, fy};
   endfunction

   task automatic check_zero(input string p);
      chk({p, "_req_ready"}, REQ_READY, '0);
      chk({p, "_wr_en"}, BUF_WR_EN, '0);
      chk({p, "_wr_idx"}, BUF_WR_IDX, '0);
      chk({p, "_force_x"}, BUF_FORCE_X, '0);
      chk({p, "_force_y"}, BUF_FORCE_Y, '0);
      chk({p, "_clear"}, BUF_CLEAR, '0);
      chk({p, "_frame_valid"}, BUF_FRAME_VALID, '0);
      chk({p, "_busy"}, BUSY, '0);
      chk({p, "_frame_done"}, FRAME_DONE, '0);
      chk({p, "_err_dup"}, ERR_DUP, '0);
   endtask

   // One clock cycle: entered and left at posedge+1
   task automatic step();
      logic [39:0]   e0;
      logic [39:0]   e1;
      logic [39:0]   e;
      logic [NR-1:0] exp_rdy;
      int            g;
      int            c;
      e0 = {8'($urandom), $urandom};
      e1 = {8'($urandom), $urandom};
      REQ_VALID = '0;
      if (q0.size() > 0) begin
         e0 = q0[0];
         if (int'($urandom_range(99)) >= gap_pct) REQ_VALID[0] = 1'b1;
      end
      if (q1.size() > 0) begin
         e1 = q1[0];
         if (int'($urandom_range(99)) >= gap_pct) REQ_VALID[1] = 1'b1;
      end
      REQ_IDX = {e1[39:32], e0[39:32]};
      REQ_FX  = {e1[31:16], e0[31:16]};
      REQ_FY  = {e1[15:0], e0[15:0]};
      ABORT = 1'b0;
      if (m_phase == P_IDLE) ABORT = 1'($urandom_range(1));
      if (abort_at >= 0 && m_phase == P_COLLECT && m_cnt >= abort_at && REQ_VALID != '0) begin
         ABORT    = 1'b1;
         abort_at = -1;
      end
      START = start_req | (start_noise && m_phase != P_IDLE);
      if (m_phase == P_STREAM) BUF_DONE = (stream_cyc >= done_delay);
      else BUF_DONE = ($urandom_range(3) == 0);

      @(negedge CLK_IN);
      g = -1;
      if (m_phase == P_COLLECT) begin
         for (int k = 0; k < NR; k++) begin
            c = (m_ptr + k) % NR;
            if (g < 0 && REQ_VALID[c]) g = c;
         end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", REQ_READY, exp_rdy);
      chk("buf_wr_en", BUF_WR_EN, m_pend);
      if (m_pend) begin
         chk("buf_wr_idx", BUF_WR_IDX, m_pidx);
         chk("buf_force_x", BUF_FORCE_X, m_pfx);
         chk("buf_force_y", BUF_FORCE_Y, m_pfy);
      end
      chk("buf_frame_valid", BUF_FRAME_VALID, m_phase == P_STREAM);
      chk("buf_clear", BUF_CLEAR, m_phase == P_CLR);
      chk("frame_done", FRAME_DONE, m_phase == P_CLR);
      chk("busy", BUSY, m_phase != P_IDLE);
      chk("err_dup", ERR_DUP, m_err);
      if (BUF_WR_EN) begin
         buf_mem[BUF_WR_IDX] = {BUF_FORCE_X, BUF_FORCE_Y};
         dut_wr_cnt++;
      end

      // Advance the model across the coming edge
      m_pend = 1'b0;
      if (g >= 0) begin
         e = (g == 0) ? q0.pop_front() : q1.pop_front();
         m_pend = 1'b1;
         m_pidx = e[39:32];
         m_pfx  = e[31:16];
         m_pfy  = e[15:0];
         m_ptr  = (g + 1) % NR;
         if (m_written[m_pidx]) m_err = 1'b1;
         else begin
            m_written[m_pidx] = 1'b1;
            m_cnt++;
         end
      end
      case (m_phase)
         P_IDLE: if (START) begin
            m_phase   = P_COLLECT;
            m_written = '{default: 1'b0};
            m_cnt     = 0;
            m_ptr     = 0;
            m_err     = 1'b0;
         end
         P_COLLECT: begin
            if (ABORT) m_phase = P_CLR;
            else if (m_cnt == N) m_phase = P_LAST;
         end
         P_LAST:   m_phase = ABORT ? P_CLR : P_STREAM;
         P_STREAM: if (ABORT || BUF_DONE) m_phase = P_CLR;
         default:  m_phase = P_IDLE;
      endcase
      if (m_phase == P_STREAM) stream_cyc++;
      else stream_cyc = 0;

      @(posedge CLK_IN);
      #1;
   endtask

   task automatic run_frame(input int exp_writes, input string name);
      int budget;
      dut_wr_cnt = 0;
      start_req  = 1'b1;
      step();
      start_req  = 1'b0;
      budget = 0;
      while (m_phase != P_IDLE && budget < 3000) begin
         step();
         budget++;
      end
      if (m_phase != P_IDLE) chk({name, "_timeout"}, budget, 0);
      if (exp_writes >= 0) chk({name, "_writes"}, dut_wr_cnt, exp_writes);
      $display("frame %s: %0d buffer writes observed, err_dup=%0d", name, dut_wr_cnt, ERR_DUP);
   endtask

   task automatic fill_random(input bit with_dup);
      int perm [N];
      int j;
      int t;
      logic [39:0] e;
      q0.delete();
      q1.delete();
      for (int i = 0; i < N; i++) perm[i] = i;
      for (int i = N - 1; i > 0; i--) begin
         j = int'($urandom_range(i, 0));
         t = perm[i];
         perm[i] = perm[j];
         perm[j] = t;
      end
      for (int i = 0; i < N; i++) begin
         e = ent(perm[i], 16'($urandom), 16'($urandom));
         if ($urandom_range(1) == 0) q0.push_back(e);
         else q1.push_back(e);
         if (with_dup && i == 10) q0.push_back(ent(perm[3], 16'($urandom), 16'($urandom)));
      end
   endtask

   initial begin
      int budget;
      // Power-on reset
      #2 RESET_IN = 1'b0;
      repeat (2) @(negedge CLK_IN);
      check_zero("reset");
      @(posedge CLK_IN);
      #2 RESET_IN = 1'b1;
      @(posedge CLK_IN);
      #1;

      // Frame A: requester 0 alone, in-order, START held high outside IDLE
      q0.delete();
      q1.delete();
      for (int i = 0; i < N; i++) q0.push_back(ent(i, 16'(i), ~16'(i)));
      gap_pct = 0; done_delay = 6; start_noise = 1'b1;
      run_frame(256, "single");
      chk("single_mem0", buf_mem[0], {16'h0000, 16'hFFFF});
      chk("single_mem128", buf_mem[128], {16'h0080, 16'hFF7F});
      chk("single_mem255", buf_mem[255], {16'h00FF, 16'hFF00});
      start_noise = 1'b0;

      // Frame B: both requesters always valid, evens on 0 and odds on 1
      q0.delete();
      q1.delete();
      for (int i = 0; i < N; i += 2) begin
         q0.push_back(ent(i, 16'($urandom), 16'($urandom)));
         q1.push_back(ent(i + 1, 16'($urandom), 16'($urandom)));
      end
      done_delay = 0;
      run_frame(256, "alternate");

      // Frame C: requester 1 writes idx 5 twice, idx 255 arrives last
      q0.delete();
      q1.delete();
      for (int i = 0; i < N; i += 2) q0.push_back(ent(i, 16'(i), ~16'(i)));
      for (int i = 1; i < N; i += 2) begin
         q1.push_back(ent(i, 16'(i), ~16'(i)));
         if (i == 5) q1.push_back(ent(5, 16'hAAAA, 16'h5555));
      end
      done_delay = 2;
      run_frame(257, "duplicate");
      chk("dup_overwrite_idx5", buf_mem[5], {16'hAAAA, 16'h5555});

      // Frame D: random traffic with a duplicate, aborted at count 100 alongside a grant
      fill_random(1'b1);
      gap_pct = 30; abort_at = 100;
      run_frame(-1, "abort");

      // Frame E: random traffic, START noise during the frame, random stream length
      fill_random(1'b1);
      abort_at = -1; start_noise = 1'b1; done_delay = int'($urandom_range(20, 1));
      run_frame(257, "random_dup");
      start_noise = 1'b0;

      // Frame F: reset asserted between edges while streaming
      fill_random(1'b1);
      done_delay = 100000;
      start_req = 1'b1;
      step();
      start_req = 1'b0;
      budget = 0;
      while (m_phase != P_STREAM && budget < 3000) begin
         step();
         budget++;
      end
      if (m_phase != P_STREAM) chk("reach_stream_timeout", budget, 0);
      $display("frame reset_mid_stream: reached streaming after %0d cycles", budget);
      #2 RESET_IN = 1'b0;
      #1 check_zero("async_reset");
      START = 1'b1;
      repeat (3) begin
         @(negedge CLK_IN);
         chk("reset_hold_busy", BUSY, 1'b0);
         chk("reset_hold_frame_valid", BUF_FRAME_VALID, 1'b0);
      end
      @(posedge CLK_IN);
      #2;
      START = 1'b0;
      RESET_IN = 1'b1;
      m_phase = P_IDLE; m_pend = 1'b0; m_err = 1'b0; m_ptr = 0; stream_cyc = 0;
      @(posedge CLK_IN);
      #1;
      q0.delete();
      q1.delete();
      step();

      // Frame G: clean random frame after reset recovery
      fill_random(1'b0);
      done_delay = 4;
      run_frame(256, "post_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/force_frame_sequencer.md
Name: force_frame_sequencer

Overview:
Controller in front of the 256-entry force output buffer.
- Arbitrates force writes from NUM_REQ compute-core requesters onto the buffer's single random-write port.
- Tracks which particle indices have been written in the current frame.
- Once every index is written, raises the buffer's frame-valid so the buffer streams the frame.
- After the buffer reports done, clears it and returns to idle for the next frame.

Parameters:
N, 256, particles per frame (buffer depth)
IDX_BITS, $clog2(N), particle index width
NUM_REQ, 2, number of compute-core requesters (2..8)

Ports:
CLK_IN  in  1  clock
RESET_IN  in  1  reset, asynchronous, active-low
START  in  1  begin collecting a new frame; honoured only in IDLE
ABORT  in  1  abandon the current frame from any non-IDLE state
REQ_VALID  in  NUM_REQ  per-requester write request
REQ_IDX  in  NUM_REQ*IDX_BITS  packed particle indices, requester i at [i*IDX_BITS +: IDX_BITS]
REQ_FX  in  NUM_REQ*16  packed force X values
REQ_FY  in  NUM_REQ*16  packed force Y values
REQ_READY  out  NUM_REQ  one-hot grant; a write transfers when REQ_VALID[i] and REQ_READY[i] are both high
BUF_WR_EN  out  1  buffer write enable (registered)
BUF_WR_IDX  out  IDX_BITS  buffer write index
BUF_FORCE_X  out  16  buffer write data X
BUF_FORCE_Y  out  16  buffer write data Y
BUF_CLEAR  out  1  buffer read-pointer clear
BUF_FRAME_VALID  out  1  buffer frame-valid
BUF_DONE  in  1  buffer done flag (level)
BUSY  out  1  high in every state except IDLE
FRAME_DONE  out  1  one-cycle pulse when a frame completes or is aborted
ERR_DUP  out  1  sticky: an index was written twice in one frame

Behaviour:
- Reset (async, RESET_IN=0):
  - State=IDLE; all outputs 0; bitmap and count cleared; round-robin pointer=0; ERR_DUP=0.
- States: IDLE, COLLECT, DRAIN, STREAM, CLR.
- IDLE:
  - REQ_READY=0.
  - START=1 → COLLECT. On that edge: bitmap cleared, count=0, pointer=0, ERR_DUP=0.
- COLLECT:
  - Round-robin arbitration, combinational from REQ_VALID and the pointer.
  - Search starts at the pointer, wraps modulo NUM_REQ; first valid requester is granted.
  - At most one grant per cycle. A requester with REQ_VALID=0 is never granted.
  - On a transfer from requester g: pointer ← (g+1) mod NUM_REQ.
  - Next cycle: BUF_WR_EN=1 with the registered idx/X/Y (1-cycle latency). BUF_WR_EN=0 in every cycle with no transfer.
  - If bitmap[idx] is 0: set it and increment count.
  - If bitmap[idx] is already 1: write is still forwarded (overwrite); ERR_DUP←1; count unchanged.
  - Transfer that makes count reach N → DRAIN. REQ_READY=0 from DRAIN onward.
- DRAIN (1 cycle):
  - Last BUF_WR_EN is presented in this cycle.
  - → STREAM, so frame-valid never overlaps an in-flight write.
- STREAM:
  - BUF_FRAME_VALID=1; REQ_READY=0.
  - Wait for BUF_DONE=1 → CLR.
- CLR (1 cycle):
  - BUF_FRAME_VALID=0, BUF_CLEAR=1, FRAME_DONE=1.
  - → IDLE.
- ABORT:
  - Applies in COLLECT, DRAIN and STREAM; → CLR on the next edge.
  - A write granted in the same cycle as ABORT is still issued on BUF_WR_EN next cycle.
  - ABORT has priority over START, the count reaching N, and BUF_DONE.
- START outside IDLE: ignored. START and ABORT together in IDLE: START wins (ABORT is meaningless in IDLE).
- Counter: IDX_BITS+1 bits wide, so the value N is representable.
- ERR_DUP: clears only on reset or on an accepted START.
- Reset asserted mid-frame: immediate return to IDLE with all outputs 0. The buffer's own reset clears its read side.

Decomposition:
- Shared package nbody_pkg:
  - FORCE_W=16
  - state enum seq_state_t {IDLE, COLLECT, DRAIN, STREAM, CLR}
  - default N
- One sub-module rr_arbiter (parameter NUM_REQ):
  - inputs: req, advance, grant_idx_in
  - output: one-hot grant
  - contains the pointer register and async reset
- Bitmap, counter and FSM live in the top module.

Test Plan:
- Reset, then START; requester 0 alone writes idx 0..255 with X=idx, Y=~idx.
  → BUF_WR_EN trails each grant by 1 cycle with matching data; DRAIN for 1 cycle; BUF_FRAME_VALID rises.
  → Drive BUF_DONE=1: CLR for 1 cycle with BUF_CLEAR=FRAME_DONE=1; back to IDLE; BUSY=0.
- Both requesters valid every cycle, req0 writes even indices, req1 odd.
  → Grants alternate 0,1,0,1 strictly; frame completes after exactly 256 transfers.
- Requester 1 writes idx 5 twice.
  → ERR_DUP=1; count stays 255 after 256 transfers; no DRAIN until idx 255 written (257 transfers); buffer holds the second value at idx 5.
- ABORT at count=100 with a grant in the same cycle.
  → That write appears on BUF_WR_EN; next state CLR; FRAME_DONE pulses; new START clears ERR_DUP and the bitmap.
- Assert RESET_IN low mid-STREAM between clock edges.
  → All outputs 0 immediately (asynchronous); START is ignored while reset is held.
- START asserted during STREAM.
  → No effect; state unchanged until BUF_DONE.
